branch_sequencer: RTL and testbench

//  Program-counter sequencer for the core. It owns the PC register and the IDLE/RUN/DONE run control.
//  It drives the 5-bit index into the jump-target lookup table.
//  It selects the next PC from: increment, LUT jump target, return address, or hold.

---
 rtl/branch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: owns ProgCtr, IDLE/RUN/DONE run control and LUT-based jumps.
// Define CALL_RET_EN to add the RET_DEPTH-entry return-address stack for Call/Ret.
module branch_sequencer #(
  parameter int PC_W        = 12,
  parameter int IDX_W       = 5,
  parameter int NUM_TARGETS = 13,
  parameter int RET_DEPTH   = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic             Halt,
  input  logic             Call,
  input  logic             Ret,
  input  logic [IDX_W-1:0] Jptr,
  input  logic [PC_W-1:0]  Jump,
  output logic [IDX_W-1:0] LutIdx,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Busy,
  output logic             Done,
  output logic             BadTarget,
  output logic             StackErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [IDX_W:0] NUM_T = (IDX_W+1)'(NUM_TARGETS);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            bad_q, bad_d;
  logic            idx_ok;

  assign pc_inc = pc_q + 1'b1;
  assign idx_ok = {1'b0, Jptr} < NUM_T;

`ifdef CALL_RET_EN
  localparam int SP_W = $clog2(RET_DEPTH + 1);
  localparam int AW   = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RET_DEPTH);

  logic [PC_W-1:0] stack_q [RET_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d, sp_m1;
  logic [AW-1:0]   push_idx, top_idx;
  logic            serr_q, serr_d;
  logic            push_en;

  assign sp_m1    = sp_q - 1'b1;
  assign top_idx  = sp_m1[AW-1:0];
  assign push_idx = sp_q[AW-1:0];
`else
  logic unused_cfg;
  assign unused_cfg = Ret & (RET_DEPTH > 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
`ifdef CALL_RET_EN
    sp_d    = sp_q;
    serr_d  = serr_q;
    push_en = 1'b0;
`endif
    if (!Stall) begin
      case (state_q)
        IDLE: if (Start) state_d = RUN;
        DONE: begin
          if (Start) begin
            state_d = RUN;
            pc_d    = '0;
            bad_d   = 1'b0;
`ifdef CALL_RET_EN
            sp_d    = '0;
            serr_d  = 1'b0;
`endif
          end
        end
        RUN: begin
          if (Halt) begin
            state_d = DONE;
`ifdef CALL_RET_EN
          end else if (Ret) begin
            if (sp_q == '0) begin
              serr_d  = 1'b1;
              state_d = DONE;
            end else begin
              sp_d = sp_m1;
              pc_d = stack_q[top_idx];
            end
          end else if (Call) begin
            // Illegal index is reported before any stack-capacity check.
            if (!idx_ok) begin
              bad_d   = 1'b1;
              state_d = DONE;
            end else if (sp_q == SP_FULL) begin
              serr_d  = 1'b1;
              state_d = DONE;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
              pc_d    = Jump;
            end
`else
          end else if (Call) begin
            if (!idx_ok) begin
              bad_d   = 1'b1;
              state_d = DONE;
            end else begin
              pc_d = Jump;
            end
`endif
          end else if (BranchEn && Taken) begin
            if (!idx_ok) begin
              bad_d   = 1'b1;
              state_d = DONE;
            end else begin
              pc_d = Jump;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

`ifdef CALL_RET_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sp_q   <= '0;
      serr_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      serr_q <= serr_d;
    end
  end

  // Entries are only meaningful below sp_q, so the storage needs no reset.
  always_ff @(posedge Clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign StackErr = serr_q;
`else
  assign StackErr = 1'b0;
`endif

  assign LutIdx    = Jptr;
  assign ProgCtr   = pc_q;
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign BadTarget = bad_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, corner sequences, randomized model run.
module tb_branch_sequencer;
  localparam int PC_W  = 12;
  localparam int IDX_W = 5;
  localparam int NT    = 13;
  localparam int DEPTH = 4;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start, Stall, BranchEn, Taken, Halt, Call, Ret;
  logic [IDX_W-1:0] Jptr;
  logic [PC_W-1:0]  Jump;
  logic [IDX_W-1:0] LutIdx;
  logic [PC_W-1:0]  ProgCtr;
  logic             Busy, Done, BadTarget, StackErr;

  logic [PC_W-1:0] lut [32];

  branch_sequencer #(.PC_W(PC_W), .IDX_W(IDX_W), .NUM_TARGETS(NT), .RET_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .Taken(Taken), .Halt(Halt), .Call(Call), .Ret(Ret), .Jptr(Jptr), .Jump(Jump),
    .LutIdx(LutIdx), .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done),
    .BadTarget(BadTarget), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;
  always_comb Jump = lut[LutIdx];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] obs();
    return {16'd0, StackErr, BadTarget, Done, Busy, ProgCtr};
  endfunction

  function automatic logic [31:0] expv(input logic [11:0] pc, input bit busy, input bit done,
                                       input bit bad, input bit serr);
    return {16'd0, serr, bad, done, busy, pc};
  endfunction

  task automatic drive(input bit st, input bit stl, input bit br, input bit tk, input bit hl,
                       input bit cl, input bit rt, input logic [4:0] jp);
    Start = st; Stall = stl; BranchEn = br; Taken = tk; Halt = hl; Call = cl; Ret = rt; Jptr = jp;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Behavioural reference: run mode, PC, sticky flags and a queue as the return stack.
  int              m_state;  // 0 idle, 1 running, 2 finished
  logic [11:0]     m_pc;
  bit              m_bad, m_serr;
  logic [11:0]     m_stack[$];

  task automatic model_reset();
    m_state = 0; m_pc = 12'd0; m_bad = 0; m_serr = 0; m_stack.delete();
  endtask

  task automatic model_edge(input bit st, input bit stl, input bit br, input bit tk, input bit hl,
                            input bit cl, input bit rt, input int jp);
    bit legal;
    legal = (jp < NT);
    if (stl) return;
    if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 2) begin
      if (st) begin
        m_state = 1; m_pc = 12'd0; m_bad = 0; m_serr = 0; m_stack.delete();
      end
    end else begin
      if (hl) m_state = 2;
`ifdef CALL_RET_EN
      else if (rt) begin
        if (m_stack.size() == 0) begin m_serr = 1; m_state = 2; end
        else m_pc = m_stack.pop_back();
      end else if (cl) begin
        if (!legal) begin m_bad = 1; m_state = 2; end
        else if (m_stack.size() == DEPTH) begin m_serr = 1; m_state = 2; end
        else begin m_stack.push_back(m_pc + 12'd1); m_pc = lut[jp]; end
      end
`else
      else if (cl) begin
        if (!legal) begin m_bad = 1; m_state = 2; end
        else m_pc = lut[jp];
      end
`endif
      else if (br && tk) begin
        if (!legal) begin m_bad = 1; m_state = 2; end
        else m_pc = lut[jp];
      end else m_pc = m_pc + 12'd1;
    end
  endtask

  typedef struct {
    bit          start, stall, br, tk, halt;
    logic [4:0]  jptr;
    logic [11:0] pc;
    bit          busy, done, bad;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit stl, input bit br, input bit tk, input bit hl,
                              input logic [4:0] jp, input logic [11:0] pc,
                              input bit busy, input bit done, input bit bad);
    vec_t v;
    v.start = st; v.stall = stl; v.br = br; v.tk = tk; v.halt = hl; v.jptr = jp;
    v.pc = pc; v.busy = busy; v.done = done; v.bad = bad;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 12'($urandom);
    lut[2] = 12'd7; lut[3] = 12'h023; lut[4] = 12'd80; lut[5] = 12'd10;
    lut[7] = 12'hFFF; lut[9] = 12'd155;

    //              st stl br tk hl jptr   pc      busy done bad
    vecs[0]  = mk(1, 0, 0, 0, 0, 5'd0,  12'd0,   1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 5'd0,  12'd1,   1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 5'd0,  12'd2,   1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 5'd0,  12'd3,   1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 5'd0,  12'd4,   1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 5'd0,  12'd5,   1, 0, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 5'd4,  12'd80,  1, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 0, 5'd4,  12'd81,  1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 1, 0, 5'd4,  12'd81,  1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0, 5'd20, 12'd82,  1, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 5'd0,  12'd83,  1, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 5'd20, 12'd83,  0, 1, 1);
    vecs[12] = mk(0, 0, 1, 1, 0, 5'd4,  12'd83,  0, 1, 1);
    vecs[13] = mk(1, 0, 0, 0, 0, 5'd0,  12'd0,   1, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 0, 5'd7,  12'hFFF, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 5'd0,  12'h000, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 0, 5'd2,  12'd7,   1, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 1, 5'd4,  12'd7,   0, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 5'd0,  12'd7,   0, 1, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 5'd0,  12'd0,   1, 0, 0);

    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0);
    tick();
    check("reset_state", obs(), expv(12'd0, 0, 0, 0, 0));
    Reset_n = 1'b1;
    tick();
    check("idle_hold", obs(), expv(12'd0, 0, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].tk, vecs[i].halt, 0, 0, vecs[i].jptr);
      tick();
      check($sformatf("vec%0d", i), obs(),
            expv(vecs[i].pc, vecs[i].busy, vecs[i].done, vecs[i].bad, 0));
      check($sformatf("vec%0d_lutidx", i), 32'(LutIdx), 32'(vecs[i].jptr));
    end

    // Asynchronous reset in the middle of a run.
    drive(0, 0, 1, 1, 0, 0, 0, 5'd3);
    tick();
    check("pre_reset_pc", obs(), expv(12'h023, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", obs(), expv(12'd0, 0, 0, 0, 0));
    tick();
    Reset_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 5'd0);
    tick();
    check("restart", obs(), expv(12'd0, 1, 0, 0, 0));
    drive(0, 0, 1, 1, 0, 0, 0, 5'd5);
    tick();
    check("goto10", obs(), expv(12'd10, 1, 0, 0, 0));

`ifdef CALL_RET_EN
    drive(0, 0, 0, 0, 0, 1, 0, 5'd9);
    tick();
    check("call", obs(), expv(12'd155, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0);
    tick();
    check("ret", obs(), expv(12'd11, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 1, 1, 5'd9);
    tick();
    check("callret_underflow", obs(), expv(12'd11, 0, 1, 0, 1));
    drive(1, 0, 0, 0, 0, 0, 0, 5'd0);
    tick();
    check("clear_serr", obs(), expv(12'd0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 5'd9);
      tick();
      check($sformatf("nest%0d", i), obs(), expv(12'd155, 1, 0, 0, 0));
    end
    tick();
    check("overflow", obs(), expv(12'd155, 0, 1, 0, 1));
`else
    drive(0, 0, 0, 0, 0, 1, 0, 5'd9);
    tick();
    check("call_as_jump", obs(), expv(12'd155, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0);
    tick();
    check("ret_ignored", obs(), expv(12'd156, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 1, 0, 5'd20);
    tick();
    check("call_bad_idx", obs(), expv(12'd156, 0, 1, 1, 0));
`endif

    // Randomized run against the reference model.
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0);
    tick();
    Reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      bit st, stl, br, tk, hl, cl, rt;
      int jp;
      st  = ($urandom_range(7) == 0);
      stl = ($urandom_range(7) == 0);
      br  = ($urandom_range(2) == 0);
      tk  = 1'($urandom_range(1));
      hl  = ($urandom_range(31) == 0);
      cl  = ($urandom_range(7) == 0);
      rt  = ($urandom_range(7) == 0);
      jp  = ($urandom_range(9) == 0) ? int'($urandom_range(31, 13)) : int'($urandom_range(12));
      drive(st, stl, br, tk, hl, cl, rt, 5'(jp));
      model_edge(st, stl, br, tk, hl, cl, rt, jp);
      tick();
      check($sformatf("rand%0d", n), obs(),
            expv(m_pc, m_state == 1, m_state == 2, m_bad, m_serr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
